// File: rtl/local_inject_arb.sv
// Local-port injection controller: two requester FIFOs (core, io) share the router's
// local input through round-robin arbitration and a registered, back-pressured output stage.
module local_inject_arb #(
    parameter  int TRANS_W = 64,
    parameter  int DEPTH   = 4,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               core_req_valid,
    input  logic [TRANS_W-1:0] core_req,
    output logic               core_req_ready,
    input  logic               io_req_valid,
    input  logic [TRANS_W-1:0] io_req,
    output logic               io_req_ready,
    output logic               out_local_req_valid,
    output logic [TRANS_W-1:0] out_local_req,
    output logic               out_local_src,
    input  logic               in_local_ready,
    output logic [CNT_W-1:0]   core_occ,
    output logic [CNT_W-1:0]   io_occ
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Index 0 is the core requester, index 1 the io requester throughout.
    logic [1:0]         req_valid;
    logic [TRANS_W-1:0] req_data [2];
    logic [1:0]         ready;
    logic [1:0]         push;
    logic [1:0]         pop;
    logic [1:0]         not_empty;

    logic [TRANS_W-1:0] mem_q    [2][DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q [2];
    logic [PTR_W-1:0]   wr_ptr_d [2];
    logic [PTR_W-1:0]   rd_ptr_q [2];
    logic [PTR_W-1:0]   rd_ptr_d [2];
    logic [CNT_W-1:0]   occ_q    [2];
    logic [CNT_W-1:0]   occ_d    [2];

    logic               out_valid_q, out_valid_d;
    logic [TRANS_W-1:0] out_data_q,  out_data_d;
    logic               out_src_q,   out_src_d;
    logic               last_grant_q, last_grant_d;

    logic               load;
    logic               grant;

    assign req_valid   = {io_req_valid, core_req_valid};
    assign req_data[0] = core_req;
    assign req_data[1] = io_req;

    // Ready comes from registered occupancy only, so a full FIFO refuses a push
    // even on the edge it is popped.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ready[i]     = (occ_q[i] != FULL_CNT);
            not_empty[i] = (occ_q[i] != '0);
            push[i]      = req_valid[i] & ready[i];
        end
    end

    // NOTE: every signal assigned in an always_comb gets a default at the top;
    // a path that leaves one unassigned infers a latch.
    always_comb begin
        load  = en && (!out_valid_q || in_local_ready) && (|not_empty);
        grant = 1'b0;
        if (&not_empty) begin
            grant = ~last_grant_q;
        end else begin
            grant = ~not_empty[0];
        end
        pop = 2'b00;
        if (load) begin
            pop = grant ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
            occ_d[i]    = occ_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;
        if (load) begin
            out_valid_d  = 1'b1;
            out_data_d   = mem_q[grant][rd_ptr_q[grant]];
            out_src_d    = grant;
            last_grant_d = grant;
        end else if (in_local_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                occ_q[i]    <= '0;
            end
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                occ_q[i]    <= occ_d[i];
            end
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; an entry is only read after
    // it has been written, and pointers/occupancy carry the reset state.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= req_data[i];
            end
        end
    end

    assign core_req_ready      = ready[0];
    assign io_req_ready        = ready[1];
    assign core_occ            = occ_q[0];
    assign io_occ              = occ_q[1];
    assign out_local_req_valid = out_valid_q;
    assign out_local_req       = out_data_q;
    assign out_local_src       = out_src_q;

endmodule

// File: doc/local_inject_arb.md
Name: local_inject_arb

Overview:
- Injection controller for the router's local port inside a fabric tile.
- Buffers transactions from two local requesters: the mini_core (requester 0, "core") and the tile IO/TB injector (requester 1, "io").
- Shares the single local input between them by round-robin arbitration and drives the router's in_local_req_valid / in_local_req through a registered, back-pressured output stage.

Parameters:
- TRANS_W, 64, width of one tile transaction (packed t_tile_trans width in the fabric build).
- DEPTH, 4, entries per requester FIFO; power of 2, minimum 2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived; not overridden).

Ports:
- clk  in  1  fabric clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  arbiter enable; 0 = hold new grants (drain gate for configuration).
- core_req_valid  in  1  core requester has a transaction.
- core_req  in  TRANS_W  core transaction payload.
- core_req_ready  out  1  core FIFO can accept.
- io_req_valid  in  1  io requester has a transaction.
- io_req  in  TRANS_W  io transaction payload.
- io_req_ready  out  1  io FIFO can accept.
- out_local_req_valid  out  1  to router in_local_req_valid.
- out_local_req  out  TRANS_W  to router in_local_req.
- out_local_src  out  1  source of the current output: 0 = core, 1 = io.
- in_local_ready  in  1  router local input accepts (reduced ready from the router).
- core_occ  out  CNT_W  core FIFO occupancy.
- io_occ  out  CNT_W  io FIFO occupancy.

Behaviour:
- Reset (rst=0, async):
  - Both FIFOs are emptied (pointers and occupancy to 0).
  - out_local_req_valid=0, out_local_req=0, out_local_src=0.
  - Internal last_grant=1 (io), so core wins the first tie.
  - core_req_ready and io_req_ready read 1 once rst is released.
  - A reset mid-transfer discards all buffered and in-output transactions; nothing is replayed.
- FIFO push:
  - x_req_ready = (x_occ < DEPTH), decoded from registered occupancy only.
  - Push on the rising edge where x_req_valid && x_req_ready.
  - A full FIFO does not accept a push, even in the same cycle it is popped.
  - Pointers wrap modulo DEPTH.
- Output register load condition: load = en && (!out_local_req_valid || in_local_ready) && (core_occ != 0 || io_occ != 0).
- Grant selection:
  - Only one FIFO non-empty: that FIFO is granted.
  - Both non-empty: grant = !last_grant.
  - On load: the head of the granted FIFO is popped into out_local_req, out_local_src = grant, last_grant = grant, and out_local_req_valid = 1.
- Output deassertion:
  - When in_local_ready=1, out_local_req_valid=1 and no load occurs, out_local_req_valid goes to 0 on that edge.
  - out_local_req and out_local_src hold their last values.
- Stall: while out_local_req_valid=1 and in_local_ready=0, out_local_req and out_local_src are stable and no pop occurs.
- Back-to-back:
  - Output handshake and a new load can occur on the same edge, giving 1 transaction per cycle sustained.
  - Alternation is core/io/core/... when both FIFOs stay non-empty.
- Latency:
  - A push into an empty FIFO at edge E, with the output idle, gives out_local_req_valid=1 after edge E+1.
  - There is no same-cycle bypass.
- en=0:
  - No new load occurs. A transaction already in the output register completes its handshake normally.
  - FIFOs continue to accept pushes until full.
  - last_grant is unchanged while en=0.
- Occupancy: a simultaneous push and pop on the same FIFO leaves its occupancy unchanged. Occupancy never exceeds DEPTH and never underflows.
- Order: ordering is preserved within each requester; there is no ordering guarantee across requesters.

Test Plan:
- Reset release, then core pushes A at edge E, with in_local_ready=1 -> out_local_req_valid=1 with out_local_req=A and out_local_src=0 after E+1; valid drops on the next edge; core_occ goes 1 then 0.
- Both requesters push 3 each (core C0-C2, io I0-I2) while in_local_ready=1 -> output sequence is C0,I0,C1,I1,C2,I2 on consecutive cycles.
- Hold in_local_ready=0 and push 5 to core -> core_req_ready goes 0 after occ=4 (one entry also sits in the output register); out_local_req stays at the first item for all stalled cycles; after release, all 5 emerge in order.
- Full FIFO with core_req_valid=1 held, then a single pop -> no push on the pop edge; push accepted on the following edge; core_occ reads 4,3,4.
- en=0 with both FIFOs loaded and one item in the output register -> that item completes and no further valid is asserted; after en=1, grant resumes with the requester opposite last_grant.
- Assert rst=0 asynchronously mid-stream (between clock edges) -> out_local_req_valid=0 immediately and both occupancies=0; the first post-reset tie grants core.
